// File: rtl/difficulty_check.sv
// Difficulty screening of SHA hash results: latches a difficulty code, looks up the
// leading-zero mask and captures the nonce of the first hash that meets it.

module difficulty_map (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [3:0]  addr_i,
  output logic [15:0] mask_o
);

  localparam int unsigned MASK_W = 16;

  logic [MASK_W-1:0] mask_q;
  logic [MASK_W-1:0] mask_d;

  // Code c requires the top c digest bits to be zero.
  always_comb begin
    mask_d = mask_q;
    if (en_i) mask_d = ~(16'hFFFF >> addr_i);
  end

  always_ff @(posedge clk) begin
    if (reset) mask_q <= '0;
    else       mask_q <= mask_d;
  end

  assign mask_o = mask_q;

endmodule

module difficulty_check #(
  parameter int unsigned NONCE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_load,
  input  logic [3:0]             difficulty_addr,
  input  logic                   hash_valid,
  input  logic [15:0]            hash_top,
  input  logic [NONCE_WIDTH-1:0] hash_nonce,
  input  logic                   clear,
  output logic                   ready,
  output logic                   success,
  output logic [NONCE_WIDTH-1:0] success_nonce,
  output logic                   halt,
  output logic [31:0]            hash_count
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned MASK_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2,
    FOUND = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   success_q, success_d;
  logic [NONCE_WIDTH-1:0] nonce_q, nonce_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [MASK_W-1:0]      mask;
  logic                   hash_pass_c;

  difficulty_map u_map (
    .clk    (clk),
    .reset  (reset),
    .en_i   (cfg_load),
    .addr_i (difficulty_addr),
    .mask_o (mask)
  );

  assign hash_pass_c = ((hash_top & mask) == 16'h0000);

  // Next-state: cfg_load overrides everything, clear only matters in FOUND.
  always_comb begin
    state_d   = state_q;
    success_d = success_q;
    nonce_d   = nonce_q;
    count_d   = count_q;
    if (cfg_load) begin
      state_d   = LOAD;
      success_d = 1'b0;
      nonce_d   = '0;
      count_d   = '0;
    end else begin
      unique case (state_q)
        IDLE:  state_d = IDLE;
        LOAD:  state_d = ARMED;
        ARMED: begin
          if (hash_valid) begin
            if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
            if (hash_pass_c) begin
              success_d = 1'b1;
              nonce_d   = hash_nonce;
              state_d   = FOUND;
            end
          end
        end
        FOUND: begin
          if (clear) begin
            success_d = 1'b0;
            state_d   = ARMED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    ready_d = (state_d == ARMED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      success_q <= 1'b0;
      nonce_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      success_q <= success_d;
      nonce_q   <= nonce_d;
      count_q   <= count_d;
    end
  end

  assign ready         = ready_q;
  assign success       = success_q;
  assign halt          = success_q;
  assign success_nonce = nonce_q;
  assign hash_count    = count_q;

endmodule

// File: tb/tb_difficulty_check.sv
// Directed bench for difficulty_check with hand-computed expectations.

module tb_difficulty_check;

  localparam int unsigned NW = 32;

  logic          clk = 1'b0;
  logic          reset, cfg_load, hash_valid, clear;
  logic [3:0]    difficulty_addr;
  logic [15:0]   hash_top;
  logic [NW-1:0] hash_nonce;
  logic          ready, success, halt;
  logic [NW-1:0] success_nonce;
  logic [31:0]   hash_count;

  int n_checks = 0;
  int n_fails  = 0;

  difficulty_check #(.NONCE_WIDTH(NW)) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_load        (cfg_load),
    .difficulty_addr (difficulty_addr),
    .hash_valid      (hash_valid),
    .hash_top        (hash_top),
    .hash_nonce      (hash_nonce),
    .clear           (clear),
    .ready           (ready),
    .success         (success),
    .success_nonce   (success_nonce),
    .halt            (halt),
    .hash_count      (hash_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hash(input logic [15:0] top, input logic [31:0] n);
    hash_valid = 1'b1;
    hash_top   = top;
    hash_nonce = n;
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic suc,
                            input logic [31:0] non, input logic [31:0] cnt);
    check({tag, ".ready"},   32'(ready),   32'(rdy));
    check({tag, ".success"}, 32'(success), 32'(suc));
    check({tag, ".halt"},    32'(halt),    32'(suc));
    check({tag, ".nonce"},   success_nonce, non);
    check({tag, ".count"},   hash_count,    cnt);
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b0; hash_valid = 1'b0; clear = 1'b0;
    difficulty_addr = 4'h0; hash_top = 16'h0; hash_nonce = '0;
    tick(); tick();
    reset = 1'b0;
    check_outs("reset", 1'b0, 1'b0, 32'h0, 32'h0);

    // Code 4 (mask F000): 0x0FFF passes on first ARMED cycle
    cfg_load = 1'b1; difficulty_addr = 4'h4; tick();
    cfg_load = 1'b0;
    check("c4.load_ready", 32'(ready), 32'h0);
    tick();
    check("c4.armed_ready", 32'(ready), 32'h1);
    hash(16'h0FFF, 32'h11); tick();
    hash_valid = 1'b0;
    check_outs("c4.found", 1'b0, 1'b1, 32'h11, 32'h1);

    // Code 8 (mask FF00): first fails, second captured, third ignored
    cfg_load = 1'b1; difficulty_addr = 4'h8; tick();
    cfg_load = 1'b0;
    check_outs("c8.load", 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    hash(16'h0100, 32'h1); tick();
    check("c8.fail_success", 32'(success), 32'h0);
    hash(16'h0080, 32'h2); tick();
    hash(16'h00FF, 32'h3); tick();
    hash_valid = 1'b0;
    check_outs("c8.found", 1'b0, 1'b1, 32'h2, 32'h2);

    // Code 0: hash during LOAD dropped, first ARMED hash passes
    cfg_load = 1'b1; difficulty_addr = 4'h0; tick();
    cfg_load = 1'b0;
    hash(16'hFFFF, 32'h5); tick();
    check_outs("c0.after_load_hash", 1'b1, 1'b0, 32'h0, 32'h0);
    hash(16'hFFFF, 32'h6); tick();
    hash_valid = 1'b0;
    check_outs("c0.found", 1'b0, 1'b1, 32'h6, 32'h1);

    // clear with a passing hash: hash dropped, re-arm, then recapture
    clear = 1'b1; hash(16'h0000, 32'h7); tick();
    clear = 1'b0; hash_valid = 1'b0;
    check_outs("clr.armed", 1'b1, 1'b0, 32'h6, 32'h1);
    hash(16'h0000, 32'h8); tick();
    hash_valid = 1'b0;
    check_outs("clr.recapture", 1'b0, 1'b1, 32'h8, 32'h2);

    // cfg_load with a passing hash while ARMED: hash dropped
    clear = 1'b1; tick();
    clear = 1'b0;
    check("cl.armed_ready", 32'(ready), 32'h1);
    cfg_load = 1'b1; difficulty_addr = 4'h0; hash(16'h0000, 32'h9); tick();
    cfg_load = 1'b0; hash_valid = 1'b0;
    check_outs("cl.load", 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check_outs("cl.rearmed", 1'b1, 1'b0, 32'h0, 32'h0);

    // clear outside FOUND has no effect
    clear = 1'b1; tick();
    clear = 1'b0;
    check_outs("clr.noop", 1'b1, 1'b0, 32'h0, 32'h0);

    // Code F (mask FFFE): count saturates, bit 0 is don't-care
    cfg_load = 1'b1; difficulty_addr = 4'hF; tick();
    cfg_load = 1'b0; tick();
    force dut.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.count_q;
    for (int i = 0; i < 3; i++) begin
      hash(16'hFFFF, 32'(i + 16)); tick();
    end
    hash_valid = 1'b0;
    check_outs("sat.count", 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF);
    hash(16'h0002, 32'h20); tick();
    check("cF.bit1_fails", 32'(success), 32'h0);
    hash(16'h0001, 32'h21); tick();
    hash_valid = 1'b0;
    check_outs("cF.found", 1'b0, 1'b1, 32'h21, 32'hFFFF_FFFF);

    // Reset in FOUND returns everything to reset values
    reset = 1'b1; tick();
    reset = 1'b0;
    check_outs("rst.found", 1'b0, 1'b0, 32'h0, 32'h0);
    hash(16'h0000, 32'h30); tick();
    hash_valid = 1'b0;
    check_outs("rst.idle_hash", 1'b0, 1'b0, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/difficulty_check.md
# difficulty_check

Downstream consumer of the difficulty mask produced by `difficulty_map`, which it instantiates internally. On `cfg_load` it latches a 4-bit difficulty code and looks up the corresponding 16-bit leading-bit mask. It then screens a stream of hash results from the SHA core against that mask and captures the nonce of the first passing hash. It holds a sticky success flag and a `halt` signal until software clears or reloads it.

## Interface
Parameters:
- `NONCE_WIDTH`, default 32: width of nonce carried alongside each hash.

Ports:
- `clk` input 1: sole clock; all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `cfg_load` input 1: one-cycle pulse; latch `difficulty_addr`, restart search.
- `difficulty_addr` input 4: difficulty code 0x0–0xF, sampled only when `cfg_load`=1.
- `hash_valid` input 1: `hash_top`/`hash_nonce` valid this cycle.
- `hash_top` input 16: most-significant 16 bits of final digest, in target order.
- `hash_nonce` input NONCE_WIDTH: nonce that produced `hash_top`.
- `clear` input 1: one-cycle pulse; leave FOUND, resume search with same mask.
- `ready` output 1: block is ARMED and accepting hashes.
- `success` output 1: sticky; passing hash captured.
- `success_nonce` output NONCE_WIDTH: nonce of first passing hash.
- `halt` output 1: equals `success`; tells the core to stop issuing nonces.
- `hash_count` output 32: hashes accepted since last `cfg_load`, saturating.

## Operation
- States: IDLE, LOAD, ARMED, FOUND.
- IDLE: entered on `reset`; waits for `cfg_load`.
- LOAD: entered from any state on `cfg_load`. The internal `difficulty_map` is driven with `en`=`cfg_load` and `addr`=`difficulty_addr`. Same edge:
  - clear `success`, `success_nonce`, `hash_count`;
  - go to LOAD.
  - LOAD lasts one cycle while the mask register settles, then goes to ARMED.
- ARMED: a hash is accepted when `hash_valid`=1.
  - Pass condition: (`hash_top` & mask) == 16'h0000. A mask bit of 1 means that digest bit must be zero.
  - Accepted hash: `hash_count` increments, saturating at 0xFFFF_FFFF.
  - Passing hash: on the same edge, `success_nonce`<=`hash_nonce`, `success`<=1, state goes to FOUND.
- FOUND: `hash_valid` is ignored, `hash_count` is frozen, and `success_nonce` is held.
  - `clear` → ARMED with `success`<=0, mask unchanged. `success_nonce` keeps its value until the next capture.
- `clear` outside FOUND: no effect.
- Mask semantics: code 0 means mask 0x0000, so every hash passes. Code 0xF means 15 leading zero bits required; bit 0 is don't-care.
- Priority, same cycle: `reset` > `cfg_load` > `clear` > `hash_valid`. A hash arriving alongside a higher-priority event is dropped and not counted.

## Timing
- Reset values:
  - state IDLE;
  - `ready`=0, `success`=0, `halt`=0;
  - `success_nonce`=0, `hash_count`=0;
  - internal mask 0x0000.
- `cfg_load` at cycle N:
  - cycle N+1: LOAD, `ready`=0;
  - cycle N+2: ARMED, `ready`=1.
  - A hash is first accepted in cycle N+2.
- Hash accepted in cycle M: `success`, `success_nonce`, `hash_count` and `halt` update and are visible in cycle M+1. Any hash in cycle M+1 is already ignored if M passed.
- `clear` in cycle K (in FOUND): `success`=0 and `ready`=1 in K+1. A hash in K+1 is accepted.
- Back-to-back `hash_valid` every cycle is supported. There is no backpressure; `ready`=0 means the hash is discarded.
- `reset` or `cfg_load` mid-search discards all in-flight results. No stale `success` may appear afterward.

## Test plan
- Reset, then `cfg_load` with code 0x4, then `hash_top`=0x0FFF, nonce 0x11 in cycle N+2 → `success`=1, `success_nonce`=0x11, `hash_count`=1 in cycle N+3.
- Code 0x8, hashes 0x0100 (n=1), 0x0080 (n=2), 0x00FF (n=3) → first fails; `success_nonce`=2; third ignored; `hash_count`=2.
- Code 0x0, any hash on the first ARMED cycle → immediate success. Also check that a hash in the LOAD cycle (N+1) is not counted.
- In FOUND, `clear` and `hash_valid` (passing) asserted together → hash dropped, `ready`=1 next cycle, `hash_count` unchanged; next passing hash recaptures.
- `cfg_load` with `hash_valid` (passing) in the same cycle while ARMED → no success, `hash_count`=0, `ready` low for one cycle.
- Preload `hash_count` to 0xFFFF_FFFE via force, then feed 3 failing hashes (code 0xF, `hash_top`=0xFFFF) → count saturates at 0xFFFF_FFFF. Separately, `reset` asserted in FOUND → all outputs return to reset values.
